counter_mod_updn: RTL

Parametrised modulo-M up/down counter with enable, synchronous clear, parallel load, wrap/saturate mode and a terminal-count strobe for cascading. It is the general counting primitive of the wall-clock/alarm datapath: chained instances form the seconds (mod 60), minutes (mod 60) and hours (mod 24 or 12) fields, and the same block serves the set-time and set-alarm adjust paths, which need down-counting.

---
 rtl/counter_mod_updn.sv | 96 +++++++++
 1 files changed

// File: rtl/counter_mod_updn.sv
// ----------------------------------------------------------------------------
// counter_mod_updn
//   Modulo-MODULO up/down counter with enable, synchronous clear, clamped
//   parallel load, wrap or saturate at the ends, and a combinational
//   terminal-count strobe so that instances can be cascaded (tc -> next en,
//   up_dn shared) to form the seconds/minutes/hours fields of a clock.
//
// Parameters
//   WIDTH    count width in bits (2**WIDTH >= MODULO)
//   MODULO   number of states, count ranges 0..MODULO-1 (MODULO >= 2)
//   SATURATE 0 = wrap at the ends, 1 = hold at the ends
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   en          count enable, one step per clock while high
//   up_dn       1 = increment, 0 = decrement
//   clear       synchronous clear to 0 (highest priority)
//   load        synchronous parallel load (clamped to MODULO-1)
//   load_value  value loaded when load is high
//   count       registered count
//   tc          terminal-count strobe (combinational)
//   at_max      registered flag, count == MODULO-1
//   at_min      registered flag, count == 0
// ----------------------------------------------------------------------------
module counter_mod_updn #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_max_q, at_max_d;
  logic             at_min_q, at_min_d;

  // Next count: clear > load > en > hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (en) begin
      if (up_dn) begin
        if (at_max_q) count_d = SAT ? MAX_VAL : '0;
        else          count_d = count_q + WIDTH'(1);
      end else begin
        if (at_min_q) count_d = SAT ? '0 : MAX_VAL;
        else          count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Flags are derived from the next count so they register in step with it.
  always_comb begin
    at_max_d = (count_d == MAX_VAL);
    at_min_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  // Strobe also fires in saturate mode so a downstream stage sees the boundary.
  always_comb begin
    tc = en & ~clear & ~load & ((up_dn & at_max_q) | (~up_dn & at_min_q));
  end

  assign count  = count_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;

endmodule
